// File: rtl/ram_pkg.sv
// Shared definitions for the word-array RAM: controller state encoding and
// request-direction constants.
package ram_pkg;

    // Controller states: zero-fill sweep, waiting for a request, response pulse
    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } state_t;

    // Value of the rw request bit for each direction
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/ram_row.sv
// One storage word of the RAM. The row has no reset of its own: the top-level
// controller zero-fills every row with a sweep after each reset.
module ram_row #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] word_q;

    // Capture the write data when this row is addressed
    always_ff @(posedge clk) begin
        if (we) begin
            word_q <= d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/ram_word_array.sv
// Clocked word RAM: DEPTH words of WIDTH bits behind a sel/rw/addr request
// port with rdy/ack handshake and registered read data. After every reset the
// controller sweeps all rows to zero before raising rdy. One access completes
// every two cycles (accept in IDLE, ack pulse in RESP).
// Optional feature macro: RAM_PARITY_EN adds an even-parity bit per word, a
// par_inj test input and a par_err status output.
module ram_word_array
    import ram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             rw,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] in,
`ifdef RAM_PARITY_EN
    input  logic             par_inj,
    output logic             par_err,
`endif
    output logic             rdy,
    output logic             ack,
    output logic [WIDTH-1:0] out,
    output logic             err
);

`ifdef RAM_PARITY_EN
    localparam int ROW_BITS = WIDTH + 1;
`else
    localparam int ROW_BITS = WIDTH;
`endif

    // DEPTH widened by one bit so that DEPTH == 2**AW still compares correctly
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               err_q, err_d;
`ifdef RAM_PARITY_EN
    logic               par_err_q, par_err_d;
`endif

    // Single write port into the row array, shared by the sweep and requests
    logic               wr_en;
    logic [AW-1:0]      wr_idx;
    logic [ROW_BITS-1:0] wr_word;

    logic [DEPTH-1:0]    row_we;
    logic [ROW_BITS-1:0] row_q [DEPTH];
    logic [ROW_BITS-1:0] rd_word;
    logic                addr_ok;

    assign addr_ok = ({1'b0, addr} < DEPTH_EXT);

    // Row storage with one-hot write-enable decode
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row
            assign row_we[gi] = wr_en && (wr_idx == AW'(gi));
            ram_row #(
                .W (ROW_BITS)
            ) u_row (
                .clk (clk),
                .we  (row_we[gi]),
                .d   (wr_word),
                .q   (row_q[gi])
            );
        end
    endgenerate

    // Read mux: selects the addressed row; only used when addr_ok
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                rd_word = row_q[i];
            end
        end
    end

    // Controller next-state, sweep, request decode and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        err_d     = err_q;
`ifdef RAM_PARITY_EN
        par_err_d = par_err_q;
`endif
        wr_en     = 1'b0;
        wr_idx    = cnt_q;
        wr_word   = '0;
        rdy       = 1'b0;
        ack       = 1'b0;

        case (state_q)
            INIT: begin
                // Zero word[cnt]; an all-zero word already has even parity
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_word = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            IDLE: begin
                rdy = 1'b1;
                if (sel) begin
                    state_d = RESP;
                    if (!addr_ok) begin
                        // Out-of-range: no memory access, read data untouched
                        err_d = 1'b1;
`ifdef RAM_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else if (rw == RW_WRITE) begin
                        wr_en  = 1'b1;
                        wr_idx = addr;
`ifdef RAM_PARITY_EN
                        wr_word   = {(^in) ^ par_inj, in};
                        par_err_d = 1'b0;
`else
                        wr_word = in;
`endif
                        err_d = 1'b0;
                    end else if (rw == RW_READ) begin
                        out_d = rd_word[WIDTH-1:0];
                        err_d = 1'b0;
`ifdef RAM_PARITY_EN
                        par_err_d = rd_word[WIDTH] ^ (^rd_word[WIDTH-1:0]);
`endif
                    end
                end
            end

            RESP: begin
                ack     = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, sweep counter and output registers; reset restarts the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
`ifdef RAM_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            err_q     <= err_d;
`ifdef RAM_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign out = out_q;
    assign err = err_q;
`ifdef RAM_PARITY_EN
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_ram_word_array.sv
// Directed bench for ram_word_array: one 16-word instance (a) and one 10-word
// instance (b) with 4 address bits. Expected responses are pushed to a
// scoreboard queue when a request is driven and popped on its ack.
module tb_ram_word_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel_a, rw_a, rdy_a, ack_a, err_a;
    logic [3:0] addr_a;
    logic [7:0] in_a, out_a;
    logic       sel_b, rw_b, rdy_b, ack_b, err_b;
    logic [3:0] addr_b;
    logic [7:0] in_b, out_b;
`ifdef RAM_PARITY_EN
    logic       inj_a, inj_b, perr_a, perr_b;
`endif

    ram_word_array #(.WIDTH(8), .DEPTH(16), .AW(4)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel_a),
        .rw      (rw_a),
        .addr    (addr_a),
        .in      (in_a),
`ifdef RAM_PARITY_EN
        .par_inj (inj_a),
        .par_err (perr_a),
`endif
        .rdy     (rdy_a),
        .ack     (ack_a),
        .out     (out_a),
        .err     (err_a)
    );

    ram_word_array #(.WIDTH(8), .DEPTH(10), .AW(4)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel_b),
        .rw      (rw_b),
        .addr    (addr_b),
        .in      (in_b),
`ifdef RAM_PARITY_EN
        .par_inj (inj_b),
        .par_err (perr_b),
`endif
        .rdy     (rdy_b),
        .ack     (ack_b),
        .out     (out_b),
        .err     (err_b)
    );

    typedef struct {
        logic [7:0] out;
        logic       err;
        logic       par;
    } exp_t;

    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];
    logic [7:0] mem      [2][16];
    logic       bad      [2][16];
    logic [7:0] last_out [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                mem[w][i] = 8'h00;
                bad[w][i] = 1'b0;
            end
            last_out[w] = 8'h00;
        end
    endtask

    task automatic drive(input int w, input logic s, input logic wr,
                         input logic [3:0] a, input logic [7:0] d, input logic inj);
        if (w == 0) begin
            sel_a = s; rw_a = wr; addr_a = a; in_a = d;
`ifdef RAM_PARITY_EN
            inj_a = inj;
`endif
        end else begin
            sel_b = s; rw_b = wr; addr_b = a; in_b = d;
`ifdef RAM_PARITY_EN
            inj_b = inj;
`endif
        end
    endtask

    function automatic logic cur_rdy(input int w);
        return (w == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic cur_ack(input int w);
        return (w == 0) ? ack_a : ack_b;
    endfunction

    // One complete access through the handshake, checked against the model
    task automatic access(input int w, input logic wr, input logic [3:0] a,
                          input logic [7:0] d, input logic inj, input string tag);
        exp_t e;
        exp_t got;
        int   dep;
        int   n;
        dep = (w == 0) ? 16 : 10;
        if (int'(a) >= dep) begin
            e.out = last_out[w]; e.err = 1'b1; e.par = 1'b0;
        end else if (wr) begin
            mem[w][a] = d; bad[w][a] = inj;
            e.out = last_out[w]; e.err = 1'b0; e.par = 1'b0;
        end else begin
            e.out = mem[w][a]; e.err = 1'b0; e.par = bad[w][a];
            last_out[w] = e.out;
        end
        sb.push_back(e);

        @(negedge clk);
        drive(w, 1'b1, wr, a, d, inj);
        n = 0;
        while (!cur_rdy(w) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check({tag, "_rdy_timeout"}, 32'd0, 32'd1);
            drive(w, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        drive(w, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        @(negedge clk);
        check({tag, "_ack"}, 32'(cur_ack(w)), 32'd1);
        check({tag, "_rdy_in_resp"}, 32'(cur_rdy(w)), 32'd0);
        got = sb.pop_front();
        check({tag, "_out"}, 32'((w == 0) ? out_a : out_b), 32'(got.out));
        check({tag, "_err"}, 32'((w == 0) ? err_a : err_b), 32'(got.err));
`ifdef RAM_PARITY_EN
        check({tag, "_par_err"}, 32'((w == 0) ? perr_a : perr_b), 32'(got.par));
`endif
        @(negedge clk);
        check({tag, "_ack_single"}, 32'(cur_ack(w)), 32'd0);
        $display("[TB] %s dut=%0d %s addr=%0d data=%0h -> out=%0h err=%0b",
                 tag, w, wr ? "WR" : "RD", a, d, got.out, got.err);
    endtask

    initial begin
        int na, nb, k, acks;
        logic       op_wr   [4];
        logic [3:0] op_addr [4];
        logic [7:0] op_data [4];

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdy", 32'(rdy_a), 32'd0);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_out", 32'(out_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
`ifdef RAM_PARITY_EN
        check("rst_par_err", 32'(perr_a), 32'd0);
`endif

        // 1. Sweep length, then every word reads zero
        rst_n = 1'b1;
        na = -1; nb = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (na < 0 && rdy_a) na = c;
            if (nb < 0 && rdy_b) nb = c;
        end
        check("t1_sweep_cycles_16", 32'(na), 32'd16);
        check("t1_sweep_cycles_10", 32'(nb), 32'd10);
        for (int i = 0; i < 16; i++) begin
            access(0, 1'b0, 4'(i), 8'h00, 1'b0, "t1_read_zero");
        end

        // 2. Write then read back
        access(0, 1'b1, 4'd3, 8'hA5, 1'b0, "t2_write");
        access(0, 1'b0, 4'd3, 8'h00, 1'b0, "t2_read");

        // 3. sel held high, alternating write/read: accept every second edge
        op_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
        op_addr = '{4'd5, 4'd5, 4'd6, 4'd6};
        op_data = '{8'h11, 8'h00, 8'h22, 8'h00};
        k = 0; acks = 0;
        @(negedge clk);
        drive(0, 1'b1, op_wr[0], op_addr[0], op_data[0], 1'b0);
        for (int c = 0; c < 8; c++) begin
            if ((c % 2) == 0) begin
                check("t3_rdy_even", 32'(rdy_a), 32'd1);
                check("t3_no_dup_ack", 32'(ack_a), 32'd0);
            end else begin
                check("t3_ack_odd", 32'(ack_a), 32'd1);
                if (ack_a) acks++;
                if (op_wr[k]) begin
                    mem[0][op_addr[k]] = op_data[k];
                end else begin
                    check("t3_read_out", 32'(out_a), 32'(mem[0][op_addr[k]]));
                    last_out[0] = mem[0][op_addr[k]];
                end
                $display("[TB] t3 op=%0d %s addr=%0d out=%0h", k,
                         op_wr[k] ? "WR" : "RD", op_addr[k], out_a);
                k++;
                if (k < 4) drive(0, 1'b1, op_wr[k], op_addr[k], op_data[k], 1'b0);
                else       drive(0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
            end
            @(negedge clk);
        end
        check("t3_ack_count", 32'(acks), 32'd4);

        // 4. Out-of-range on the 10-word instance, boundaries 9 and 10
        access(1, 1'b1, 4'd2,  8'h77, 1'b0, "t4_write");
        access(1, 1'b0, 4'd2,  8'h00, 1'b0, "t4_read");
        access(1, 1'b0, 4'd12, 8'h00, 1'b0, "t4_oob_read");
        access(1, 1'b0, 4'd9,  8'h00, 1'b0, "t4_last_word");
        access(1, 1'b1, 4'd10, 8'hEE, 1'b0, "t4_oob_write");
        access(1, 1'b0, 4'd2,  8'h00, 1'b0, "t4_err_clear");

        // 5. Reset during RESP aborts the ack and reruns the sweep
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        @(negedge clk);
        check("t5_ack_before_rst", 32'(ack_a), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_ack_drop", 32'(ack_a), 32'd0);
        check("t5_rdy_low", 32'(rdy_a), 32'd0);
        check("t5_out_cleared", 32'(out_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        na = -1;
        for (int c = 1; c <= 40 && na < 0; c++) begin
            @(negedge clk);
            if (rdy_a) na = c;
        end
        check("t5_resweep_cycles", 32'(na), 32'd16);
        access(0, 1'b0, 4'd7, 8'h00, 1'b0, "t5_read_after_rst");

`ifdef RAM_PARITY_EN
        // 6. Injected parity error, then a clean word
        access(0, 1'b1, 4'd4, 8'h0F, 1'b1, "t6_write_inj");
        access(0, 1'b0, 4'd4, 8'h00, 1'b0, "t6_read_inj");
        access(0, 1'b1, 4'd5, 8'h0F, 1'b0, "t6_write_clean");
        access(0, 1'b0, 4'd5, 8'h00, 1'b0, "t6_read_clean");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
